// File: rtl/register_file.sv
// RV32I integer register file: 32 x 32-bit registers, x0 hardwired to zero.
// Two combinational read ports and one synchronous write port. Reset clears
// every register asynchronously.
module register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] readS1,
  input  logic [ADDR_WIDTH-1:0] readS2,
  input  logic [ADDR_WIDTH-1:0] readRd,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] rs1,
  output logic [DATA_WIDTH-1:0] rs2
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NumRegs];
  logic [DATA_WIDTH-1:0] regs_d [NumRegs];

  // Next-state: only the addressed register changes; x0 writes are dropped.
  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (en && (readRd != '0)) begin
      regs_d[readRd] = data_in;
    end
  end

  // Register array with asynchronous clear; reset wins over a coincident write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports: no write-to-read forwarding; x0 forced to zero.
  always_comb begin
    rs1 = (readS1 == '0) ? '0 : regs_q[readS1];
    rs2 = (readS2 == '0) ? '0 : regs_q[readS2];
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: vector table plus hand-written reset,
// same-cycle read/write and asynchronous reset sequences.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        en;
  logic [4:0]  readS1;
  logic [4:0]  readS2;
  logic [4:0]  readRd;
  logic [31:0] data_in;
  logic [31:0] rs1;
  logic [31:0] rs2;

  int n_cmp  = 0;
  int n_fail = 0;

  register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .readS1 (readS1),
    .readS2 (readS2),
    .readRd (readRd),
    .data_in(data_in),
    .rs1    (rs1),
    .rs2    (rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    // {en, rd, data, s1, s2, exp rs1, exp rs2} -- reads checked after the edge
    vecs[0] = '{1'b1, 5'd5,  32'd10,         5'd5,  5'd0,  32'd10,         32'd0};
    vecs[1] = '{1'b0, 5'd10, 32'd10,         5'd10, 5'd5,  32'd0,          32'd10};
    vecs[2] = '{1'b1, 5'd0,  32'd10,         5'd0,  5'd0,  32'd0,          32'd0};
    vecs[3] = '{1'b1, 5'd1,  32'hFFFF_FFFF,  5'd1,  5'd5,  32'hFFFF_FFFF,  32'd10};
    vecs[4] = '{1'b1, 5'd5,  32'hA5A5_A5A5,  5'd5,  5'd1,  32'hA5A5_A5A5,  32'hFFFF_FFFF};
    vecs[5] = '{1'b1, 5'd2,  32'd1,          5'd2,  5'd2,  32'd1,          32'd1};
    vecs[6] = '{1'b0, 5'd2,  32'd0,          5'd2,  5'd10, 32'd1,          32'd0};
    vecs[7] = '{1'b1, 5'd30, 32'h8000_0000,  5'd30, 5'd31, 32'h8000_0000,  32'd0};
    vecs[8] = '{1'b1, 5'd31, 32'h1111_1111,  5'd31, 5'd30, 32'h1111_1111,  32'h8000_0000};

    rst = 1'b0; en = 1'b0; readS1 = '0; readS2 = '0; readRd = '0; data_in = '0;

    // Power-on reset: every index reads zero while reset is held
    for (int i = 0; i < 32; i++) begin
      readS1 = 5'(i); readS2 = 5'(31 - i);
      #1;
      check("por_rs1", rs1, 32'd0);
      check("por_rs2", rs2, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    // Vector table; the first write lands on the first edge after release
    for (int v = 0; v < 9; v++) begin
      en = vecs[v].en; readRd = vecs[v].rd; data_in = vecs[v].data;
      readS1 = vecs[v].s1; readS2 = vecs[v].s2;
      @(posedge clk); #1;
      check($sformatf("vec%0d_rs1", v), rs1, vecs[v].exp1);
      check($sformatf("vec%0d_rs2", v), rs2, vecs[v].exp2);
    end

    // Same-cycle read of the register being written: old value, then new
    en = 1'b1; readRd = 5'd31; data_in = 32'hDEAD_BEEF; readS1 = 5'd31; readS2 = 5'd31;
    #1;
    check("x31_old_rs1", rs1, 32'h1111_1111);
    check("x31_old_rs2", rs2, 32'h1111_1111);
    @(posedge clk); #1;
    check("x31_new_rs1", rs1, 32'hDEAD_BEEF);
    check("x31_new_rs2", rs2, 32'hDEAD_BEEF);

    // Asynchronous reset between edges clears x7 before the next edge
    en = 1'b1; readRd = 5'd7; data_in = 32'h0000_1234; readS1 = 5'd7; readS2 = 5'd31;
    @(posedge clk); #1;
    en = 1'b0;
    check("x7_written", rs1, 32'h0000_1234);
    #2;
    rst = 1'b0;
    #1;
    check("x7_async_clr", rs1, 32'd0);
    check("x31_async_clr", rs2, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Repopulate, then pulse reset 10ns with a coincident write attempt
    en = 1'b1; readRd = 5'd3; data_in = 32'hCAFE_F00D; readS1 = 5'd3; readS2 = 5'd0;
    @(posedge clk); #1;
    check("x3_written", rs1, 32'hCAFE_F00D);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1; readRd = 5'd3; data_in = 32'h5555_5555;
    for (int i = 0; i < 10; i++) begin
      readS1 = 5'(i * 3); readS2 = 5'(i * 3 + 2);
      #1;
      check("pulse_rs1", rs1, 32'd0);
      check("pulse_rs2", rs2, 32'd0);
    end
    rst = 1'b1;
    en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      readS1 = 5'(i); readS2 = 5'(31 - i);
      #1;
      check("post_rs1", rs1, 32'd0);
      check("post_rs2", rs2, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
